// File: rtl/lru_ctrl_lv1.sv
// Tree pseudo-LRU controller for a 4-way L1 cache: owns the per-set PLRU array,
// clears it with an init sweep, arbitrates hit/fill updates and selects victims.
module lru_ctrl_lv1 #(
  parameter int ASSOC_WID   = 2,
  parameter int INDEX_MSB   = 11,
  parameter int INDEX_LSB   = 6,
  parameter int LRU_VAR_WID = 3,
  parameter int NUM_OF_SETS = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           init_busy,
  input  logic                           hit_upd_valid,
  input  logic [INDEX_MSB-INDEX_LSB:0]   hit_upd_index,
  input  logic [ASSOC_WID-1:0]           hit_upd_way,
  output logic                           hit_upd_ready,
  input  logic                           fill_upd_valid,
  input  logic [INDEX_MSB-INDEX_LSB:0]   fill_upd_index,
  input  logic [ASSOC_WID-1:0]           fill_upd_way,
  output logic                           fill_upd_ready,
  input  logic                           victim_req,
  input  logic [INDEX_MSB-INDEX_LSB:0]   victim_index,
  input  logic [3:0]                     valid_vec,
  output logic                           victim_ready,
  output logic                           victim_ack,
  output logic [ASSOC_WID-1:0]           victim_way
);

  localparam int IW = INDEX_MSB - INDEX_LSB + 1;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                   state_r, state_next_s;
  logic [IW-1:0]            cnt_r;
  logic                     init_busy_r;
  logic                     victim_ack_r;
  logic [ASSOC_WID-1:0]     victim_way_r;
  logic [LRU_VAR_WID-1:0]   plru_r [NUM_OF_SETS];

  logic                     fill_acc_s, hit_acc_s, vic_acc_s, upd_acc_s;
  logic [IW-1:0]            upd_idx_s;
  logic [ASSOC_WID-1:0]     upd_way_s;
  logic [LRU_VAR_WID-1:0]   upd_bits_s, vic_bits_s;
  logic [ASSOC_WID-1:0]     sel_way_s;

  // b2 root, b1 left pair, b0 right pair; accessed way is steered away from.
  function automatic logic [2:0] plru_update(input logic [2:0] s, input logic [1:0] w);
    logic [2:0] r;
    r = s;
    case (w)
      2'd0:    begin r[2] = 1'b1; r[1] = 1'b1; end
      2'd1:    begin r[2] = 1'b1; r[1] = 1'b0; end
      2'd2:    begin r[2] = 1'b0; r[0] = 1'b1; end
      2'd3:    begin r[2] = 1'b0; r[0] = 1'b0; end
      default: r = s;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] s);
    logic [1:0] w;
    if (s[2] == 1'b0) w = s[1] ? 2'd1 : 2'd0;
    else              w = s[0] ? 2'd3 : 2'd2;
    return w;
  endfunction

  function automatic logic [1:0] first_invalid(input logic [3:0] v);
    logic [1:0] w;
    if      (v[0] == 1'b0) w = 2'd0;
    else if (v[1] == 1'b0) w = 2'd1;
    else if (v[2] == 1'b0) w = 2'd2;
    else                   w = 2'd3;
    return w;
  endfunction

  assign init_busy      = init_busy_r;
  assign fill_upd_ready = !init_busy_r;
  assign hit_upd_ready  = !init_busy_r && !fill_upd_valid;
  assign victim_ready   = !init_busy_r;
  assign victim_ack     = victim_ack_r;
  assign victim_way     = victim_way_r;

  // Next-state logic of the init/ready sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == IW'(NUM_OF_SETS - 1)) state_next_s = ST_READY;
        else                               state_next_s = ST_INIT;
      end
      ST_READY: state_next_s = ST_READY;
      default:  state_next_s = ST_INIT;
    endcase
  end

  // Sequencer state, sweep counter and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      cnt_r       <= '0;
      init_busy_r <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= (state_r == ST_INIT) ? cnt_r + IW'(1) : cnt_r;
      init_busy_r <= (state_next_s == ST_INIT);
    end
  end

  // Update arbitration (fill over hit) and victim choice with same-index bypass.
  always_comb begin
    fill_acc_s = fill_upd_valid && !init_busy_r;
    hit_acc_s  = hit_upd_valid && !init_busy_r && !fill_upd_valid;
    vic_acc_s  = victim_req && !init_busy_r;
    upd_acc_s  = fill_acc_s || hit_acc_s;
    if (fill_acc_s) begin
      upd_idx_s = fill_upd_index;
      upd_way_s = fill_upd_way;
    end else begin
      upd_idx_s = hit_upd_index;
      upd_way_s = hit_upd_way;
    end
    upd_bits_s = plru_update(plru_r[upd_idx_s], upd_way_s);
    if (upd_acc_s && (upd_idx_s == victim_index)) vic_bits_s = upd_bits_s;
    else                                          vic_bits_s = plru_r[victim_index];
    if (valid_vec != 4'hF) sel_way_s = first_invalid(valid_vec);
    else                   sel_way_s = plru_victim(vic_bits_s);
  end

  // PLRU array: zeroed by the sweep, otherwise one accepted update per cycle.
  always_ff @(posedge clk) begin
    if (init_busy_r) plru_r[cnt_r] <= '0;
    else if (upd_acc_s && !rst) plru_r[upd_idx_s] <= upd_bits_s;
  end

  // Registered victim response.
  always_ff @(posedge clk) begin
    if (rst) begin
      victim_ack_r <= 1'b0;
      victim_way_r <= '0;
    end else begin
      victim_ack_r <= vic_acc_s;
      if (vic_acc_s) victim_way_r <= sel_way_s;
    end
  end

endmodule
